// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Pipeline-side bundle of the PC sequencer. It carries the
//               stall/halt/branch-resolve inputs, the shared branch-adder
//               operands and result, and the fetch PC status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
  logic        stall;
  logic        halt;
  logic        br_valid;
  logic        br_taken;
  logic [15:0] br_pc;
  logic [15:0] br_offset;
  logic [15:0] adder_pc;
  logic [15:0] adder_offset;
  logic [15:0] adder_target;
  logic [15:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        fault;
  logic [1:0]  state;

  // Pipeline / adder side: drives the control inputs and the adder sum
  modport master (
    output stall, halt, br_valid, br_taken, br_pc, br_offset, adder_target,
    input  adder_pc, adder_offset, pc, pc_valid, flush, fault, state
  );

  // Sequencer side
  modport slave (
    input  stall, halt, br_valid, br_taken, br_pc, br_offset, adder_target,
    output adder_pc, adder_offset, pc, pc_valid, flush, fault, state
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter owner for the 16-bit pipeline. It selects
//               sequential / hold / branch-redirect, drives the shared branch
//               target adder, raises flush after a taken branch, and handles
//               halt and the sticky misaligned-target fault.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          PC_INC       = 2,
  parameter int          FLUSH_CYCLES = 2
) (
  input  wire            clk,
  input  wire            rst_n,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [15:0] c_pc_inc   = 16'(PC_INC);
  localparam logic [2:0]  c_cnt_init = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic        fault_q, fault_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        take;

  // Adder operands are forced to zero when no branch resolves, so the shared
  // adder does not toggle on unrelated EX traffic.
  assign bus.adder_pc     = bus.br_valid ? bus.br_pc     : 16'h0000;
  assign bus.adder_offset = bus.br_valid ? bus.br_offset : 16'h0000;

  assign take = bus.br_valid & bus.br_taken;

  // Next-state selection; every output below is taken from a flop.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    flush_d    = flush_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (take && bus.adder_target[0]) begin
          // Odd target: freeze at the faulting point, no redirect
          state_d    = ST_HALT;
          fault_d    = 1'b1;
          pc_valid_d = 1'b0;
        end else if (take) begin
          // Branch is older than any stalled/halting instruction, so it wins
          pc_d       = bus.adder_target;
          flush_d    = 1'b1;
          cnt_d      = c_cnt_init;
          state_d    = ST_FLUSH;
          pc_valid_d = 1'b1;
        end else if (!pc_valid_q) begin
          // First cycle out of reset: the fetch at RESET_PC has not yet been
          // marked valid, so validate it rather than skipping over it.
          pc_valid_d = 1'b1;
        end else if (bus.halt && !bus.stall) begin
          state_d    = ST_HALT;
          pc_valid_d = 1'b0;
        end else if (!bus.stall) begin
          pc_d = pc_q + c_pc_inc;
        end
      end
      ST_FLUSH: begin
        // Inputs refer to wrong-path instructions and are ignored here
        pc_d = pc_q + c_pc_inc;
        if (cnt_q == 3'd0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_HALT: begin
        // Only reset leaves HALT
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.flush    = flush_q;
  assign bus.fault    = fault_q;
  assign bus.state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. Models the
//               shared branch adder and checks reset, stepping, stall,
//               taken-branch flush, wrap, halt, fault and mid-flush reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  pc_sequencer_if bus ();

  // Shared branch-target adder: 16-bit sum, wraps modulo 2^16
  assign bus.adder_target = bus.adder_pc + bus.adder_offset;

  pc_sequencer #(
    .RESET_PC     (16'h0000),
    .PC_INC       (2),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.stall     = 1'b0;
    bus.halt      = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_pc     = 16'h0000;
    bus.br_offset = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [15:0] bpc, input logic [15:0] boff);
    bus.br_valid  = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_pc     = bpc;
    bus.br_offset = boff;
  endtask

  task automatic chk_pc(input string name, input logic [15:0] exp);
    total_cnt++;
    if (bus.pc !== exp)
      $display("FAIL %s: pc got %h expected %h", name, bus.pc, exp);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk_pc("reset_pc", 16'h0000);
    total_cnt++;
    if ({bus.pc_valid, bus.flush, bus.fault} !== 3'b000)
      $display("FAIL reset_flags: valid/flush/fault got %b expected 000",
               {bus.pc_valid, bus.flush, bus.fault});
    else pass_cnt++;
    total_cnt++;
    if (bus.state !== 2'd0)
      $display("FAIL reset_state: got %0d expected 0", bus.state);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    chk_pc("start_pc0", 16'h0000);
    total_cnt++;
    if (bus.pc_valid !== 1'b1)
      $display("FAIL start_valid: got %b expected 1", bus.pc_valid);
    else pass_cnt++;
    tick(); chk_pc("step_0002", 16'h0002);
    tick(); chk_pc("step_0004", 16'h0004);
    tick(); chk_pc("step_0006", 16'h0006);
    total_cnt++;
    if (bus.flush !== 1'b0)
      $display("FAIL step_flush: got %b expected 0", bus.flush);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    while (bus.pc !== 16'h0010 && n < 20) begin
      tick();
      n++;
    end
    chk_pc("reach_0010", 16'h0010);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pc($sformatf("stall_hold%0d", i), 16'h0010);
    end
    bus.stall = 1'b0;
    tick();
    chk_pc("stall_resume", 16'h0012);
  endtask

  task automatic test_branch_flush();
    branch(16'h0008, 16'hFFF8);
    bus.stall = 1'b1;
    bus.halt  = 1'b1;
    #1;
    total_cnt++;
    if (bus.adder_pc !== 16'h0008 || bus.adder_offset !== 16'hFFF8)
      $display("FAIL adder_drive: got %h/%h expected 0008/fff8",
               bus.adder_pc, bus.adder_offset);
    else pass_cnt++;
    tick();
    chk_pc("br_target", 16'h0000);
    total_cnt++;
    if (bus.flush !== 1'b1 || bus.state !== 2'd1)
      $display("FAIL br_flush1: flush/state got %b/%0d expected 1/1",
               bus.flush, bus.state);
    else pass_cnt++;
    // Wrong-path branch pulse plus stall/halt while flushing: ignored
    branch(16'h0100, 16'h0000);
    tick();
    chk_pc("flush_pc2", 16'h0002);
    total_cnt++;
    if (bus.flush !== 1'b1 || bus.state !== 2'd1)
      $display("FAIL br_flush2: flush/state got %b/%0d expected 1/1",
               bus.flush, bus.state);
    else pass_cnt++;
    tick();
    idle();
    chk_pc("flush_end_pc", 16'h0004);
    total_cnt++;
    if (bus.flush !== 1'b0 || bus.state !== 2'd0)
      $display("FAIL flush_end: flush/state got %b/%0d expected 0/0",
               bus.flush, bus.state);
    else pass_cnt++;
    tick();
    chk_pc("after_flush", 16'h0006);
  endtask

  task automatic test_wrap();
    branch(16'h0002, 16'hFFFA);
    tick();
    idle();
    chk_pc("wrap_target", 16'hFFFC);
    total_cnt++;
    if (bus.fault !== 1'b0 || bus.state !== 2'd1)
      $display("FAIL wrap_nofault: fault/state got %b/%0d expected 0/1",
               bus.fault, bus.state);
    else pass_cnt++;
    tick(); chk_pc("wrap_fffe", 16'hFFFE);
    tick(); chk_pc("wrap_0000", 16'h0000);
    tick(); chk_pc("wrap_0002", 16'h0002);
  endtask

  task automatic test_halt_stall();
    bus.halt  = 1'b1;
    bus.stall = 1'b1;
    tick();
    chk_pc("halt_stalled_pc", 16'h0002);
    total_cnt++;
    if (bus.state !== 2'd0 || bus.pc_valid !== 1'b1)
      $display("FAIL halt_stalled: state/valid got %0d/%b expected 0/1",
               bus.state, bus.pc_valid);
    else pass_cnt++;
    bus.stall = 1'b0;
    tick();
    idle();
    total_cnt++;
    if (bus.state !== 2'd2 || bus.pc_valid !== 1'b0)
      $display("FAIL halt_enter: state/valid got %0d/%b expected 2/0",
               bus.state, bus.pc_valid);
    else pass_cnt++;
    tick();
    chk_pc("halt_frozen", 16'h0002);
  endtask

  task automatic test_reset_mid_flush();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    branch(16'h0040, 16'h0010);
    tick();
    idle();
    chk_pc("mid_target", 16'h0050);
    rst_n = 1'b0;
    tick();
    chk_pc("mid_reset_pc", 16'h0000);
    total_cnt++;
    if (bus.flush !== 1'b0 || bus.state !== 2'd0 || bus.pc_valid !== 1'b0)
      $display("FAIL mid_reset: flush/state/valid got %b/%0d/%b expected 0/0/0",
               bus.flush, bus.state, bus.pc_valid);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_fault();
    tick();
    chk_pc("fault_start", 16'h0000);
    branch(16'h0010, 16'h0003);
    tick();
    idle();
    chk_pc("fault_pc", 16'h0000);
    total_cnt++;
    if (bus.state !== 2'd2 || bus.fault !== 1'b1 || bus.pc_valid !== 1'b0)
      $display("FAIL fault_enter: state/fault/valid got %0d/%b/%b expected 2/1/0",
               bus.state, bus.fault, bus.pc_valid);
    else pass_cnt++;
    branch(16'h0020, 16'h0000);
    bus.stall = 1'b1;
    tick();
    tick();
    idle();
    chk_pc("fault_frozen", 16'h0000);
    total_cnt++;
    if (bus.state !== 2'd2 || bus.fault !== 1'b1)
      $display("FAIL fault_sticky: state/fault got %0d/%b expected 2/1",
               bus.state, bus.fault);
    else pass_cnt++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++;
    if (bus.fault !== 1'b0 || bus.state !== 2'd0)
      $display("FAIL fault_clear: fault/state got %b/%0d expected 0/0",
               bus.fault, bus.state);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    idle();
    test_reset();
    test_stall();
    test_branch_flush();
    test_wrap();
    test_halt_stall();
    test_reset_mid_flush();
    test_fault();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter for the 16-bit pipelined datapath. Each cycle it selects the next PC: sequential (PC + PC_INC), hold on stall, or a branch redirect.
- Sequences the shared branch-target adder (16-bit PC + signed 16-bit offset, combinational, wraps modulo 2^16): drives the adder inputs from the EX-stage branch and consumes its result.
- After a taken branch, asserts flush for a fixed number of cycles to kill wrong-path instructions in IF/ID. Handles halt and misaligned-target fault.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- PC_INC, 2, sequential increment in bytes.
- FLUSH_CYCLES, 2, number of cycles flush is held after a taken branch (legal range 1..7).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- stall  input  1  hazard stall from ID; hold PC
- halt  input  1  halt instruction decoded in ID
- br_valid  input  1  branch resolved in EX this cycle
- br_taken  input  1  resolved branch is taken (qualified by br_valid)
- br_pc  input  16  PC of the branch instruction
- br_offset  input  16  sign-extended branch offset
- adder_pc  output  16  to branch adder PC input
- adder_offset  output  16  to branch adder offset input
- adder_target  input  16  branch adder sum
- pc  output  16  current fetch PC (registered)
- pc_valid  output  1  fetch at pc is valid (registered)
- flush  output  1  kill IF/ID contents (registered)
- fault  output  1  sticky misaligned-target fault (registered)
- state  output  2  debug: 0 RUN, 1 FLUSH, 2 HALT

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n = 0 at a clk edge): pc = RESET_PC, pc_valid = 0, flush = 0, fault = 0, state = RUN, flush counter = 0.
- pc_valid becomes 1 at the first edge after rst_n returns high. A reset asserted mid-flush or in HALT aborts immediately to the reset values.
- Adder drive (combinational):
  - adder_pc = br_valid ? br_pc : 16'h0000.
  - adder_offset = br_valid ? br_offset : 16'h0000.
  - The redirect uses adder_target in the same cycle; there is no extra latency.
- Let take = br_valid & br_taken.
- RUN, priority order per edge:
  1. take & adder_target[0] = 1: go to HALT, fault <= 1, pc unchanged, pc_valid <= 0.
  2. take: pc <= adder_target, flush <= 1, counter <= FLUSH_CYCLES-1, go to FLUSH. A taken branch beats stall and halt, because the stalled or halting instruction is younger and gets flushed.
  3. halt & !stall: go to HALT, pc_valid <= 0, pc unchanged.
  4. stall: pc, state and outputs hold.
  5. Otherwise: pc <= pc + PC_INC.
- FLUSH:
  - flush stays 1 and pc <= pc + PC_INC every cycle.
  - stall, halt and br_valid are ignored, since they refer to flushed instructions.
  - When counter = 0: flush <= 0, go to RUN. Otherwise counter decrements.
  - flush is therefore high for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the taken branch.
- HALT: pc, pc_valid = 0 and fault hold. Only reset exits. All other inputs are ignored.
- Wrap-around:
  - pc + PC_INC wraps modulo 2^16 (16'hFFFE + 2 = 16'h0000).
  - A negative offset may wrap below zero (16'h0002 + 16'hFFFA = 16'hFFFC). This is legal and is not a fault.
- No combinational path from inputs to pc, pc_valid, flush, fault or state. Only adder_pc and adder_offset are combinational.

Test Plan:
- Reset, then release with no inputs: pc = 0000, pc_valid = 0 during reset. After release pc steps 0000, 0002, 0004, 0006; flush = 0.
- At pc = 0010, stall high for 3 cycles: pc holds at 0010 for 3 cycles, then resumes at 0012.
- Taken branch, br_pc = 0008, br_offset = FFF8 (adder_target = 0000), with stall = 1 and halt = 1 in the same cycle:
  - adder_pc = 0008 and adder_offset = FFF8 that cycle.
  - Next pc = 0000, flush = 1 for 2 cycles while pc goes 0002, 0004.
  - br_valid pulses during FLUSH are ignored; state returns to RUN.
- Taken branch with adder_target = 0013: state = HALT, fault = 1, pc_valid = 0, pc frozen. A later taken branch or stall has no effect. Reset clears fault.
- Wrap: start at pc = FFFC, free run: pc goes FFFC, FFFE, 0000. Taken branch br_pc = 0002, br_offset = FFFA redirects to FFFC with no fault.
- halt with stall = 1: no transition. When stall drops: HALT, pc_valid = 0. Reset asserted mid-FLUSH (counter nonzero): next edge pc = 0000, flush = 0, state = RUN.
